// File: rtl/video_shift_memory.sv
// ---------------------------------------------------------------------------
// video_shift_memory
//   Recirculating screen memory for the Apple-1 video terminal: an FPGA
//   stand-in for the 2504 dynamic shift-register bank. Each accepted shift
//   stores din at the current loop position and presents, on dout, the word
//   that was stored there DEPTH shifts earlier. A clear engine walks the
//   whole loop once, writing CLEAR_CODE into every position.
//
// Ports
//   clk      in   1      system clock, rising edge
//   reset    in   1      asynchronous active-high reset
//   shift    in   1      one word shifted per high cycle
//   din      in   WIDTH  word to store (from the 74157 mux)
//   dout     out  WIDTH  registered word leaving the loop
//   clr_req  in   1      single-cycle request to clear the whole memory
//   busy     out  1      high while the clear engine owns the memory
//   wrap     out  1      one-cycle pulse after a shift that moved ptr DEPTH-1 -> 0
// ---------------------------------------------------------------------------
module video_shift_memory #(
    parameter int                 WIDTH      = 7,
    parameter int                 DEPTH      = 1024,
    parameter logic [WIDTH-1:0]   CLEAR_CODE = WIDTH'(7'h20)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             clr_req,
    output logic             busy,
    output logic             wrap
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    cnt;
    logic [PW-1:0]    ptr_nxt;
    logic             shift_ok;
    logic             we;
    logic [WIDTH-1:0] wdata;

    // Memory has no reset so it can map onto block RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    // Explicit compare so non-power-of-two depths wrap correctly.
    assign ptr_nxt  = (ptr == LAST) ? '0 : ptr + 1'b1;

    // A clear request in the same cycle as a shift wins; the shift is lost.
    assign shift_ok = (state == IDLE) && shift && !clr_req;
    assign we       = !reset && ((state == CLEAR) || shift_ok);
    assign wdata    = (state == CLEAR) ? CLEAR_CODE : din;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            dout  <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else if (shift) begin
                        // Read-before-write: the old word leaves as the new one enters.
                        dout <= mem[ptr];
                        ptr  <= ptr_nxt;
                        wrap <= (ptr == LAST);
                    end
                end
                CLEAR: begin
                    // DEPTH steps of ptr bring it back to where the clear started.
                    ptr <= ptr_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
